// File: rtl/vga_pkg.sv
// Shared timing defaults, colour typedefs and the 2-to-4 bit colour expansion helper
// for the tile VGA display path.
package vga_pkg;

    localparam int unsigned H_ACT_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_ACT_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    typedef struct packed {
        logic [1:0] pad;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } colour_byte_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    // Per-pixel control bits carried down the latency-matching delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } ctl_t;

    function automatic logic [3:0] expand2to4(input logic [1:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the tile VGA: horizontal/vertical position, raw (active-high)
// sync and display-enable indications, and a pulse on the last pixel of each frame.
module vga_timing #(
    parameter int unsigned H_ACT  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_ACT  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW    = $clog2(H_TOT),
    localparam int unsigned VW    = $clog2(V_TOT)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic          frame_wrap_o
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_ACT_W  = HW'(H_ACT);
    localparam logic [VW-1:0] V_ACT_W  = VW'(V_ACT);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o       = hcnt_q;
    assign vcnt_o       = vcnt_q;
    assign hs_o         = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    assign vs_o         = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    assign de_o         = (hcnt_q < H_ACT_W) && (vcnt_q < V_ACT_W);
    assign frame_wrap_o = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/vga_tile_ctrl.sv
// Tile VGA controller: tile-memory address generation, latency-matched sync/colour
// pipeline and optional frame blinking (enabled by defining VGA_TILE_BLINK_EN).
module vga_tile_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT        = H_ACT_DEF,
    parameter int unsigned H_FP         = H_FP_DEF,
    parameter int unsigned H_SYNC       = H_SYNC_DEF,
    parameter int unsigned H_BP         = H_BP_DEF,
    parameter int unsigned V_ACT        = V_ACT_DEF,
    parameter int unsigned V_FP         = V_FP_DEF,
    parameter int unsigned V_SYNC       = V_SYNC_DEF,
    parameter int unsigned V_BP         = V_BP_DEF,
    parameter bit          SYNC_POL     = 1'b0,
    parameter int unsigned TILE_SHIFT   = 6,
    parameter int unsigned COL_BITS     = 4,
    parameter int unsigned ROW_BITS     = 3,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h80,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned BLINK_FRAMES = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        vdata,
    output logic [ADDR_W-1:0] vaddr,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS_O,
    output logic              VGA_VS_O,
    output logic              frame_start
);

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned IDX_W = COL_BITS + ROW_BITS;
    localparam int unsigned LAT   = MEM_LAT + 2;

    if (ADDR_W < IDX_W) begin : g_addr_w_chk
        $error("ADDR_W must be >= COL_BITS + ROW_BITS");
    end
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_mem_lat_chk
        $error("MEM_LAT must be in 1..4");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hs_raw, vs_raw, de_raw, frame_wrap, vis;

    vga_timing #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk_i        (clk),
        .reset_i      (reset),
        .hcnt_o       (hcnt),
        .vcnt_o       (vcnt),
        .hs_o         (hs_raw),
        .vs_o         (vs_raw),
        .de_o         (de_raw),
        .frame_wrap_o (frame_wrap)
    );

    // Tile indices are truncated to their field widths, so large rasters wrap.
    logic [COL_BITS-1:0] col_idx;
    logic [ROW_BITS-1:0] row_idx;
    logic [ADDR_W-1:0]   vaddr_q, vaddr_d;

    assign col_idx = COL_BITS'(hcnt >> TILE_SHIFT);
    assign row_idx = ROW_BITS'(vcnt >> TILE_SHIFT);

    if (ADDR_W > IDX_W) begin : g_addr_base
        assign vaddr_d = {BASE_ADDR[ADDR_W-1:IDX_W], col_idx, row_idx};
    end else begin : g_addr_nobase
        assign vaddr_d = ADDR_W'({col_idx, row_idx});
    end

`ifdef VGA_TILE_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          hidden_q, hidden_d;

    always_comb begin
        bcnt_d   = bcnt_q;
        hidden_d = hidden_q;
        if (frame_wrap) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d   = '0;
                hidden_d = ~hidden_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q   <= '0;
            hidden_q <= 1'b0;
        end else begin
            bcnt_q   <= bcnt_d;
            hidden_q <= hidden_d;
        end
    end

    assign vis = ~hidden_q;
`else
    localparam int unsigned unused_blink_frames = BLINK_FRAMES;
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
    assign vis               = 1'b1;
`endif

    // Blink visibility rides with de so it stays aligned to the frame seen at the pins.
    ctl_t ctl_raw;
    ctl_t dly_q [LAT];

    assign ctl_raw = '{hs: hs_raw, vs: vs_raw, de: de_raw & vis,
                       fs: (hcnt == '0) && (vcnt == '0)};

    colour_byte_t pix;
    rgb4_t        rgb_q, rgb_d;
    logic [1:0]   unused_pad;

    assign pix        = colour_byte_t'(vdata);
    assign unused_pad = pix.pad;

    // vdata for a pixel arrives while its control bits sit in stage LAT-2.
    always_comb begin
        rgb_d = '0;
        if (dly_q[LAT-2].de) begin
            rgb_d.r = expand2to4(pix.r);
            rgb_d.g = expand2to4(pix.g);
            rgb_d.b = expand2to4(pix.b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                dly_q[i] <= '0;
            end
            vaddr_q <= '0;
            rgb_q   <= '0;
        end else begin
            dly_q[0] <= ctl_raw;
            for (int i = 1; i < LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            vaddr_q <= vaddr_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vaddr       = vaddr_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS_O    = dly_q[LAT-1].hs ? SYNC_POL : ~SYNC_POL;
    assign VGA_VS_O    = dly_q[LAT-1].vs ? SYNC_POL : ~SYNC_POL;
    assign frame_start = dly_q[LAT-1].fs;

endmodule

// File: tb/tb_vga_tile_ctrl.sv
// Randomised bench for vga_tile_ctrl on a reduced raster, checked every clock against a
// pixel-index reference model; exercises reset, free run, truncation and mid-frame reset.
module tb_vga_tile_ctrl;

    localparam int H_ACT = 20, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACT = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int SYNC_POL = 0;
    localparam int TILE_SHIFT = 2, COL_BITS = 2, ROW_BITS = 2;
    localparam int BASE = 'h80;
    localparam int MEM_LAT = 2;
    localparam int LAT = MEM_LAT + 2;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vdata;
    logic [7:0] vaddr;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       hs, vs, fs;

    logic [7:0] mem [256];
    logic [7:0] memq [MEM_LAT];

    int checks = 0;
    int failures = 0;
    int k = 0;
    int last_fs = -1;
    int fs_seen = 0;

    always #5 clk = ~clk;

    // Tile memory: MEM_LAT register stages from vaddr to vdata.
    always @(posedge clk) begin
        memq[0] <= mem[vaddr];
        for (int i = 1; i < MEM_LAT; i++) memq[i] <= memq[i-1];
    end
    assign vdata = memq[MEM_LAT-1];

    vga_tile_ctrl #(
        .H_ACT        (H_ACT),
        .H_FP         (H_FP),
        .H_SYNC       (H_SYNC),
        .H_BP         (H_BP),
        .V_ACT        (V_ACT),
        .V_FP         (V_FP),
        .V_SYNC       (V_SYNC),
        .V_BP         (V_BP),
        .SYNC_POL     (1'b0),
        .TILE_SHIFT   (TILE_SHIFT),
        .COL_BITS     (COL_BITS),
        .ROW_BITS     (ROW_BITS),
        .ADDR_W       (8),
        .BASE_ADDR    (8'h80),
        .MEM_LAT      (MEM_LAT),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vdata       (vdata),
        .vaddr       (vaddr),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS_O    (hs),
        .VGA_VS_O    (vs),
        .frame_start (fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Address of linear pixel index p since the raster (re)started.
    function automatic int addr_of(input int p);
        int x, y;
        x = p % H_TOT;
        y = (p / H_TOT) % V_TOT;
        return BASE + (((x >> TILE_SHIFT) % (1 << COL_BITS)) << ROW_BITS)
                    + ((y >> TILE_SHIFT) % (1 << ROW_BITS));
    endfunction

    function automatic bit visible(input int p);
`ifdef VGA_TILE_BLINK_EN
        return ((p / FRAME) / BLINK) % 2 == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
        check({tag, "_hs"}, 32'(hs), 32'(1 - SYNC_POL));
        check({tag, "_vs"}, 32'(vs), 32'(1 - SYNC_POL));
        check({tag, "_fs"}, 32'(fs), 32'h0);
        check({tag, "_vaddr"}, 32'(vaddr), 32'h0);
    endtask

    task automatic step_and_check();
        int q, x, y, er, eg, eb, ehs, evs, efs;
        logic [7:0] c;
        @(posedge clk);
        #1;
        k++;
        check("vaddr", 32'(vaddr), 32'(addr_of(k - 1)));
        q = k - LAT;
        er = 0; eg = 0; eb = 0; efs = 0;
        ehs = 1 - SYNC_POL;
        evs = 1 - SYNC_POL;
        if (q >= 0) begin
            x = q % H_TOT;
            y = (q / H_TOT) % V_TOT;
            if (x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC) ehs = SYNC_POL;
            if (y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC) evs = SYNC_POL;
            efs = (q % FRAME == 0) ? 1 : 0;
            if (x < H_ACT && y < V_ACT && visible(q)) begin
                c  = mem[addr_of(q)];
                er = ((c >> 4) & 3) * 5;
                eg = ((c >> 2) & 3) * 5;
                eb = (c & 3) * 5;
            end
        end
        check("vga_r", 32'(vga_r), 32'(er));
        check("vga_g", 32'(vga_g), 32'(eg));
        check("vga_b", 32'(vga_b), 32'(eb));
        check("hs", 32'(hs), 32'(ehs));
        check("vs", 32'(vs), 32'(evs));
        check("frame_start", 32'(fs), 32'(efs));
        if (fs) begin
            if (last_fs >= 0) check("fs_period", 32'(k - last_fs), 32'(FRAME));
            last_fs = k;
            fs_seen++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_and_check();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h80] = 8'h3F;
        mem[8'h84] = 8'h24;
    endtask

    initial begin
        int r;
        fill_mem();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        last_fs = -1;
        fs_seen = 0;
        // Four frames cover both blink phases when blinking is built in.
        run(4 * FRAME + 40);
        check("fs_count_run1", 32'(fs_seen), 32'd5);

        r = $urandom_range(50, FRAME - 50);
        run(r);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        fill_mem();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_outputs("held_reset");
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        last_fs = -1;
        fs_seen = 0;
        run(FRAME + 20);
        check("fs_count_run2", 32'(fs_seen), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
